// File: rtl/mask_shift_loader_pkg.sv
// Shared constants for the MICROROC mask loader: FSM state encodings and default geometry.
// MASK_READBACK_EN (when defined) enables the VERIFY state in the loader.
package mask_shift_loader_pkg;

    localparam int MASK_WIDTH_DEF = 192;
    localparam int CLK_DIV_DEF    = 4;
    localparam int BITCNT_W       = 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LATCH    = 3'd1,
        SHIFT_LO = 3'd2,
        SHIFT_HI = 3'd3,
        VERIFY   = 3'd4,
        DONE     = 3'd5
    } state_t;

endpackage

// File: rtl/mask_shift_loader_sr_clk_tick.sv
// Half-period timer for SrClk: one-cycle tick every CLK_DIV cycles while enabled.
// The count clears whenever the enable drops, so each shift phase starts from zero.
module sr_clk_tick
    import mask_shift_loader_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic Clk,
    input  logic reset_n,
    input  logic en_i,
    output logic tick_o
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (!en_i || tick_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mask_shift_loader.sv
// Serializes the discriminator mask MSB-first into the MICROROC shift chain on LoadStart or auto mask change.
// Define MASK_READBACK_EN to add a second pass that checks SrOut against the loaded mask.
module mask_shift_loader
    import mask_shift_loader_pkg::*;
#(
    parameter int MASK_WIDTH = MASK_WIDTH_DEF,
    parameter int CLK_DIV    = CLK_DIV_DEF
) (
    input  logic                  Clk,
    input  logic                  reset_n,
    input  logic [MASK_WIDTH-1:0] MicrorocChannelDiscriminatorMask,
    input  logic                  LoadStart,
    input  logic                  AutoLoadEn,
    output logic                  SrClk,
    output logic                  SrIn,
    input  logic                  SrOut,
    output logic                  LoadBusy,
    output logic                  LoadDone,
    output logic                  ReadbackError
);

    generate
        if (MASK_WIDTH < 1 || MASK_WIDTH > 255 || CLK_DIV < 1) begin : g_bad_param
            $error("mask_shift_loader: MASK_WIDTH must be 1..255 and CLK_DIV >= 1");
        end
    endgenerate

    state_t                state_q, state_d;
    logic [BITCNT_W-1:0]   bitcnt_q, bitcnt_d;
    logic [MASK_WIDTH-1:0] shadow_q, shadow_d;
    logic [MASK_WIDTH-1:0] last_q, last_d;
    logic                  pending_q, pending_d;
    logic                  busy_q, busy_d;

    logic shift_en;
    logic tick;
    logic mask_chg;
    logic req;
    logic last_bit;
    logic [MASK_WIDTH-1:0] shadow_rot;

    assign shift_en   = (state_q == SHIFT_LO) || (state_q == SHIFT_HI) || (state_q == VERIFY);
    assign mask_chg   = AutoLoadEn && (MicrorocChannelDiscriminatorMask != last_q);
    assign req        = LoadStart || mask_chg;
    assign last_bit   = (bitcnt_q == BITCNT_W'(MASK_WIDTH - 1));
    // Shadow rotates one place per bit, so SrIn is always its MSB and a full pass restores it.
    assign shadow_rot = {shadow_q[MASK_WIDTH-2:0], shadow_q[MASK_WIDTH-1]};

    sr_clk_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .Clk    (Clk),
        .reset_n(reset_n),
        .en_i   (shift_en),
        .tick_o (tick)
    );

`ifdef MASK_READBACK_EN
    logic vphase_q, vphase_d;
    logic rberr_q, rberr_d;
`else
    logic unused_srout;
    assign unused_srout = SrOut;
`endif

    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        shadow_d  = shadow_q;
        last_d    = last_q;
        pending_d = pending_q;
        busy_d    = busy_q;
`ifdef MASK_READBACK_EN
        vphase_d  = vphase_q;
        rberr_d   = rberr_q;
`endif
        case (state_q)
            IDLE: begin
                if (req || pending_q) begin
                    state_d = LATCH;
                end
            end
            LATCH: begin
                shadow_d  = MicrorocChannelDiscriminatorMask;
                last_d    = MicrorocChannelDiscriminatorMask;
                bitcnt_d  = '0;
                pending_d = LoadStart;
                busy_d    = 1'b1;
`ifdef MASK_READBACK_EN
                rberr_d   = 1'b0;
`endif
                state_d   = SHIFT_LO;
            end
            SHIFT_LO: begin
                if (tick) begin
                    state_d = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                if (tick) begin
                    shadow_d = shadow_rot;
                    if (last_bit) begin
                        bitcnt_d = '0;
`ifdef MASK_READBACK_EN
                        vphase_d = 1'b0;
                        state_d  = VERIFY;
`else
                        state_d  = DONE;
`endif
                    end else begin
                        bitcnt_d = bitcnt_q + 8'd1;
                        state_d  = SHIFT_LO;
                    end
                end
            end
`ifdef MASK_READBACK_EN
            VERIFY: begin
                if (tick) begin
                    if (!vphase_q) begin
                        // SrOut is taken on the cycle SrClk rises, before the chip shifts.
                        vphase_d = 1'b1;
                        if (SrOut != shadow_q[MASK_WIDTH-1]) begin
                            rberr_d = 1'b1;
                        end
                    end else begin
                        vphase_d = 1'b0;
                        shadow_d = shadow_rot;
                        if (last_bit) begin
                            state_d = DONE;
                        end else begin
                            bitcnt_d = bitcnt_q + 8'd1;
                        end
                    end
                end
            end
`endif
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Requests arriving mid-load collapse into a single follow-up load.
        if (state_q != IDLE && state_q != LATCH && req) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            bitcnt_q  <= '0;
            shadow_q  <= '1;
            last_q    <= '1;
            pending_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            shadow_q  <= shadow_d;
            last_q    <= last_d;
            pending_q <= pending_d;
            busy_q    <= busy_d;
        end
    end

`ifdef MASK_READBACK_EN
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            vphase_q <= 1'b0;
            rberr_q  <= 1'b0;
        end else begin
            vphase_q <= vphase_d;
            rberr_q  <= rberr_d;
        end
    end

    assign SrClk         = (state_q == SHIFT_HI) || ((state_q == VERIFY) && vphase_q);
    assign ReadbackError = rberr_q;
`else
    assign SrClk         = (state_q == SHIFT_HI);
    assign ReadbackError = 1'b0;
`endif

    assign SrIn     = shift_en && shadow_q[MASK_WIDTH-1];
    assign LoadBusy = busy_q;
    assign LoadDone = (state_q == DONE);

endmodule

// File: tb/tb_mask_shift_loader.sv
// Bench for mask_shift_loader: vector table of load triggers plus hand-built multi-cycle sequences.
// Captured SrIn streams are scored against a queue of expected masks on every LoadDone.
module tb_mask_shift_loader;

    localparam int MW = 192;
    localparam int CD = 4;
`ifdef MASK_READBACK_EN
    localparam int LAT  = 2 + 4 * CD * MW;
    localparam int BITS = 2 * MW;
`else
    localparam int LAT  = 2 + 2 * CD * MW;
    localparam int BITS = MW;
`endif

    typedef struct {
        logic [MW-1:0] mask;
        logic          auto_en;
        logic          start;
        int            exp_loads;
    } vec_t;

    logic          Clk;
    logic          reset_n;
    logic [MW-1:0] mask;
    logic          LoadStart;
    logic          AutoLoadEn;
    logic          SrClk;
    logic          SrIn;
    logic          SrOut;
    logic          LoadBusy;
    logic          LoadDone;
    logic          ReadbackError;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ndone = 0;
    int ncap  = 0;
    int last_done_cyc = 0;
    int prev_done_cyc = 0;

    logic [MW-1:0] cap;
    logic          prev_srclk;
    logic [MW-1:0] sbq[$];
    logic [MW-1:0] chain;
    int            ccount;
    logic          inv57;

    logic [MW-1:0] pa, pb, m1, m2, m3, m4, m5;
    vec_t          vecs[6];

    mask_shift_loader #(
        .MASK_WIDTH(MW),
        .CLK_DIV   (CD)
    ) dut (
        .Clk                             (Clk),
        .reset_n                         (reset_n),
        .MicrorocChannelDiscriminatorMask(mask),
        .LoadStart                       (LoadStart),
        .AutoLoadEn                      (AutoLoadEn),
        .SrClk                           (SrClk),
        .SrIn                            (SrIn),
        .SrOut                           (SrOut),
        .LoadBusy                        (LoadBusy),
        .LoadDone                        (LoadDone),
        .ReadbackError                   (ReadbackError)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) cyc <= cyc + 1;

    // Chip-side chain model: shifts on SrClk rise, SrOut is the far end; optional single-bit corruption.
    always @(posedge SrClk or negedge reset_n) begin
        if (!reset_n) begin
            chain  <= '0;
            ccount <= 0;
        end else begin
            chain  <= {chain[MW-2:0], SrIn};
            ccount <= (ccount == 2 * MW - 1) ? 0 : ccount + 1;
        end
    end
    assign SrOut = chain[MW-1] ^ (inv57 && (ccount == MW + 57));

    task automatic check_b(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%b want=%b", name, act, exp);
        end
    endtask

    task automatic check_i(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic check_v(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic wait_done(input int target, input int limit);
        int n;
        n = 0;
        while (ndone < target && n < limit) begin
            @(posedge Clk);
            n++;
        end
    endtask

    // Monitor: capture SrIn at each SrClk rise, score the stream when LoadDone pulses.
    always @(negedge Clk) begin
        if (!reset_n) begin
            ncap       = 0;
            prev_srclk = 1'b0;
        end else begin
            if (SrClk && !prev_srclk) begin
                cap  = {cap[MW-2:0], SrIn};
                ncap = ncap + 1;
            end
            prev_srclk = SrClk;
            if (LoadDone) begin
                ndone         = ndone + 1;
                prev_done_cyc = last_done_cyc;
                last_done_cyc = cyc;
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_load_done at cycle %0d got=1 want=0", cyc);
                end else begin
                    check_v("stream", cap, sbq.pop_front());
                    check_i("bitcount", ncap, BITS);
                end
                ncap = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int t0;

        pa = {64'hDEADBEEF01234567, 64'h89ABCDEFFEDCBA98, 64'h5A5AA5A50F0FF0F0};
        pb = {64'h8000000000000001, 64'h00FF00FF00FF00FF, 64'h1234567890ABCDEF};
        m1 = ~pa;
        m2 = pa ^ pb;
        m3 = {pb[63:0], pa[127:0]};
        m4 = '1;
        m5 = ~pb;

        vecs[0] = '{mask: '1,                       auto_en: 1'b0, start: 1'b1, exp_loads: 1};
        vecs[1] = '{mask: {{189{1'b1}}, 3'b010},    auto_en: 1'b1, start: 1'b0, exp_loads: 1};
        vecs[2] = '{mask: pa,                       auto_en: 1'b1, start: 1'b1, exp_loads: 1};
        vecs[3] = '{mask: pb,                       auto_en: 1'b0, start: 1'b0, exp_loads: 0};
        vecs[4] = '{mask: pb,                       auto_en: 1'b0, start: 1'b1, exp_loads: 1};
        vecs[5] = '{mask: pb,                       auto_en: 1'b1, start: 1'b0, exp_loads: 0};

        reset_n    = 1'b1;
        LoadStart  = 1'b0;
        AutoLoadEn = 1'b0;
        mask       = '1;
        inv57      = 1'b0;
        #2 reset_n = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check_b("rst_srclk", SrClk, 1'b0);
        check_b("rst_srin", SrIn, 1'b0);
        check_b("rst_busy", LoadBusy, 1'b0);
        check_b("rst_done", LoadDone, 1'b0);
        check_b("rst_rberr", ReadbackError, 1'b0);
        @(posedge Clk);
        #1 reset_n = 1'b1;
        repeat (2) @(posedge Clk);

        for (int i = 0; i < 6; i++) begin
            @(posedge Clk);
            #1;
            base       = ndone;
            t0         = cyc;
            mask       = vecs[i].mask;
            AutoLoadEn = vecs[i].auto_en;
            LoadStart  = vecs[i].start;
            if (vecs[i].exp_loads != 0) sbq.push_back(vecs[i].mask);
            @(posedge Clk);
            #1 LoadStart = 1'b0;
            @(negedge Clk);
            check_b($sformatf("vec%0d_busy_latch", i), LoadBusy, 1'b0);
            @(negedge Clk);
            check_b($sformatf("vec%0d_busy_n2", i), LoadBusy, vecs[i].exp_loads != 0);
            repeat (LAT + 20) @(posedge Clk);
            @(negedge Clk);
            check_i($sformatf("vec%0d_loads", i), ndone - base, vecs[i].exp_loads);
            check_b($sformatf("vec%0d_busy_end", i), LoadBusy, 1'b0);
            if (vecs[i].exp_loads == 1)
                check_i($sformatf("vec%0d_latency", i), last_done_cyc - t0, LAT);
        end

        // Auto mask change in the middle of a shift queues exactly one follow-up load.
        @(posedge Clk);
        #1;
        base       = ndone;
        AutoLoadEn = 1'b1;
        mask       = m1;
        sbq.push_back(m1);
        repeat (770) @(posedge Clk);
        #1;
        check_b("midshift_busy", LoadBusy, 1'b1);
        mask = m2;
        sbq.push_back(m2);
        wait_done(base + 2, 2 * LAT + 100);
        repeat (20) @(posedge Clk);
        @(negedge Clk);
        check_i("midshift_loads", ndone - base, 2);
        check_i("midshift_gap", last_done_cyc - prev_done_cyc, LAT + 1);
        check_b("midshift_busy_end", LoadBusy, 1'b0);
        @(posedge Clk);
        #1 AutoLoadEn = 1'b0;

        // Several LoadStart pulses during one busy period collapse into one extra load.
        @(posedge Clk);
        #1;
        base      = ndone;
        mask      = m3;
        LoadStart = 1'b1;
        sbq.push_back(m3);
        sbq.push_back(m3);
        @(posedge Clk);
        #1 LoadStart = 1'b0;
        for (int k = 0; k < 3; k++) begin
            repeat (300) @(posedge Clk);
            #1 LoadStart = 1'b1;
            @(posedge Clk);
            #1 LoadStart = 1'b0;
        end
        wait_done(base + 2, 2 * LAT + 100);
        repeat (20) @(posedge Clk);
        @(negedge Clk);
        check_i("multi_start_loads", ndone - base, 2);
        check_i("multi_start_gap", last_done_cyc - prev_done_cyc, LAT + 1);
        check_b("multi_start_busy_end", LoadBusy, 1'b0);

        // Reset in the SrClk-high half of bit 100 aborts the load with nothing resuming.
        @(posedge Clk);
        #1;
        base      = ndone;
        mask      = m4;
        LoadStart = 1'b1;
        @(posedge Clk);
        #1 LoadStart = 1'b0;
        repeat (805) @(posedge Clk);
        #1;
        check_b("abort_pre_srclk", SrClk, 1'b1);
        check_b("abort_pre_srin", SrIn, 1'b1);
        check_b("abort_pre_busy", LoadBusy, 1'b1);
        reset_n = 1'b0;
        #1;
        check_b("abort_srclk", SrClk, 1'b0);
        check_b("abort_srin", SrIn, 1'b0);
        check_b("abort_busy", LoadBusy, 1'b0);
        check_b("abort_done", LoadDone, 1'b0);
        repeat (3) @(posedge Clk);
        #1 reset_n = 1'b1;
        repeat (LAT + 50) @(posedge Clk);
        @(negedge Clk);
        check_i("abort_loads", ndone - base, 0);
        check_b("abort_idle_busy", LoadBusy, 1'b0);
        check_b("abort_idle_srclk", SrClk, 1'b0);

`ifdef MASK_READBACK_EN
        // Clean readback, then a corrupted return bit 57, then a clean load clearing the flag.
        for (int r = 0; r < 3; r++) begin
            @(posedge Clk);
            #1;
            base      = ndone;
            inv57     = (r == 1);
            mask      = m5;
            LoadStart = 1'b1;
            sbq.push_back(m5);
            @(posedge Clk);
            #1 LoadStart = 1'b0;
            @(negedge Clk);
            @(negedge Clk);
            check_b($sformatf("rb%0d_cleared", r), ReadbackError, 1'b0);
            wait_done(base + 1, LAT + 100);
            repeat (2) @(posedge Clk);
            @(negedge Clk);
            check_i($sformatf("rb%0d_loads", r), ndone - base, 1);
            check_b($sformatf("rb%0d_error", r), ReadbackError, r == 1);
        end
        inv57 = 1'b0;
`else
        check_b("rberr_tied", ReadbackError, 1'b0);
`endif

        check_i("scoreboard_empty", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
